// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants, immediate formats and the ID-stage state encoding.
package riscv_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

   // LDWAIT marks the single cycle after a load left the slot; the slot itself
   // may already hold the next instruction during that cycle.
   typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_LDWAIT} id_state_e;

   function automatic imm_type_e imm_type_of(input logic [6:0] op);
      imm_type_e t;
      case (op)
         OP_LOAD, OP_IMM, OP_JALR: t = IMM_I;
         OP_STORE:                 t = IMM_S;
         OP_BRANCH:                t = IMM_B;
         OP_LUI, OP_AUIPC:         t = IMM_U;
         OP_JAL:                   t = IMM_J;
         default:                  t = IMM_NONE;
      endcase
      return t;
   endfunction

   function automatic logic is_legal_op(input logic [6:0] op);
      return (imm_type_of(op) != IMM_NONE) || (op == OP_REG) || (op == OP_SYSTEM);
   endfunction

   function automatic logic uses_rs1(input logic [6:0] op);
      return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      return (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_REG);
   endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; formats without an immediate give 0.
module imm_gen
   import riscv_pkg::*;
(
   input  logic [31:0] instr_i,
   output logic [31:0] imm_o
);

   always_comb begin
      imm_o = '0;
      case (imm_type_of(instr_i[6:0]))
         IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
         IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
         IMM_U: imm_o = {instr_i[31:12], 12'b0};
         IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
         default: imm_o = '0;
      endcase
   end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage with one ID/EX slot and load-use interlock.
// Define WB_BYPASS_EN to forward the writeback port into captured operands instead of stalling.
module id_stage
   import riscv_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        if_valid_i,
   input  logic [31:0] if_instr_i,
   input  logic [31:0] if_pc_i,
   output logic        if_ready_o,
   output logic [4:0]  r_src_1_o,
   output logic [4:0]  r_src_2_o,
   input  logic [31:0] r_src_1_dat_i,
   input  logic [31:0] r_src_2_dat_i,
   input  logic        wb_en_i,
   input  logic [4:0]  wb_rd_i,
   input  logic [31:0] wb_dat_i,
   input  logic        ex_ready_i,
   input  logic        flush_i,
   output logic        id_valid_o,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_rs1_dat_o,
   output logic [31:0] id_rs2_dat_o,
   output logic [31:0] id_imm_o,
   output logic [4:0]  id_rd_o,
   output logic [6:0]  id_opcode_o,
   output logic [2:0]  id_funct3_o,
   output logic [6:0]  id_funct7_o,
   output logic        id_is_load_o,
   output logic        id_illegal_o
);

   id_state_e   state_q, state_d;
   logic        valid_q, valid_d;
   logic [4:0]  pend_rd_q, pend_rd_d;
   logic [31:0] pc_q, rs1_dat_q, rs2_dat_q, imm_q;
   logic [4:0]  rd_q;
   logic [6:0]  opcode_q, funct7_q;
   logic [2:0]  funct3_q;
   logic        is_load_q, illegal_q;

   logic [6:0]  op;
   logic [4:0]  rs1, rs2;
   logic [31:0] imm, rs1_val, rs2_val;
   logic        slot_ld, pend_ld, hit1, hit2, wb_stall, stall, accept, load_leaves;

   assign op        = if_instr_i[6:0];
   assign rs1       = if_instr_i[19:15];
   assign rs2       = if_instr_i[24:20];
   assign r_src_1_o = rs1;
   assign r_src_2_o = rs2;

   imm_gen u_imm_gen (
      .instr_i (if_instr_i),
      .imm_o   (imm)
   );

   // A load occupying the slot or one that just left cannot yet supply its rd.
   assign slot_ld = valid_q & is_load_q & (rd_q != 5'd0);
   assign pend_ld = (state_q == ST_LDWAIT);
   assign hit1 = uses_rs1(op) & (rs1 != 5'd0) &
                 ((slot_ld & (rs1 == rd_q)) | (pend_ld & (rs1 == pend_rd_q)));
   assign hit2 = uses_rs2(op) & (rs2 != 5'd0) &
                 ((slot_ld & (rs2 == rd_q)) | (pend_ld & (rs2 == pend_rd_q)));

`ifdef WB_BYPASS_EN
   assign wb_stall = 1'b0;

   always_comb begin
      rs1_val = r_src_1_dat_i;
      rs2_val = r_src_2_dat_i;
      if (wb_en_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs1)) rs1_val = wb_dat_i;
      if (wb_en_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs2)) rs2_val = wb_dat_i;
      if (rs1 == 5'd0) rs1_val = '0;
      if (rs2 == 5'd0) rs2_val = '0;
   end
`else
   // Register-file read ports show stale data during a write cycle.
   assign wb_stall = wb_en_i;

   logic unused_wb;
   assign unused_wb = ^{wb_rd_i, wb_dat_i};

   always_comb begin
      rs1_val = (rs1 == 5'd0) ? 32'd0 : r_src_1_dat_i;
      rs2_val = (rs2 == 5'd0) ? 32'd0 : r_src_2_dat_i;
   end
`endif

   assign stall       = hit1 | hit2 | wb_stall;
   assign if_ready_o  = ~rst_i & ~flush_i & (~valid_q | ex_ready_i) & ~stall;
   assign accept      = if_valid_i & if_ready_o;
   assign load_leaves = valid_q & ex_ready_i & is_load_q & (rd_q != 5'd0);

   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      pend_rd_d = pend_rd_q;
      if (flush_i) begin
         valid_d = 1'b0;
         state_d = ST_EMPTY;
      end else begin
         if (accept)          valid_d = 1'b1;
         else if (ex_ready_i) valid_d = 1'b0;
         if (load_leaves) begin
            state_d   = ST_LDWAIT;
            pend_rd_d = rd_q;
         end else begin
            state_d = valid_d ? ST_FULL : ST_EMPTY;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_EMPTY;
         valid_q   <= 1'b0;
         pend_rd_q <= '0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         pend_rd_q <= pend_rd_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q      <= '0;
         rs1_dat_q <= '0;
         rs2_dat_q <= '0;
         imm_q     <= '0;
         rd_q      <= '0;
         opcode_q  <= '0;
         funct3_q  <= '0;
         funct7_q  <= '0;
         is_load_q <= 1'b0;
         illegal_q <= 1'b0;
      end else if (accept) begin
         pc_q      <= if_pc_i;
         rs1_dat_q <= rs1_val;
         rs2_dat_q <= rs2_val;
         imm_q     <= imm;
         rd_q      <= if_instr_i[11:7];
         opcode_q  <= op;
         funct3_q  <= if_instr_i[14:12];
         funct7_q  <= if_instr_i[31:25];
         is_load_q <= (op == OP_LOAD);
         illegal_q <= ~is_legal_op(op) | (if_instr_i[1:0] != 2'b11);
      end
   end

   assign id_valid_o   = valid_q;
   assign id_pc_o      = pc_q;
   assign id_rs1_dat_o = rs1_dat_q;
   assign id_rs2_dat_o = rs2_dat_q;
   assign id_imm_o     = imm_q;
   assign id_rd_o      = rd_q;
   assign id_opcode_o  = opcode_q;
   assign id_funct3_o  = funct3_q;
   assign id_funct7_o  = funct7_q;
   assign id_is_load_o = is_load_q;
   assign id_illegal_o = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed scenarios followed by randomized traffic.
`timescale 1ns/1ps
module tb_id_stage;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam logic [6:0] T_LOAD = 7'b0000011, T_IMM = 7'b0010011, T_JALR = 7'b1100111;
   localparam logic [6:0] T_STORE = 7'b0100011, T_BRANCH = 7'b1100011, T_LUI = 7'b0110111;
   localparam logic [6:0] T_AUIPC = 7'b0010111, T_JAL = 7'b1101111, T_REG = 7'b0110011;
   localparam logic [6:0] T_SYS = 7'b1110011;

   typedef struct packed {
      logic [31:0] pc, rs1, rs2, imm;
      logic [4:0]  rd;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        ld, ill;
   } rec_t;
   localparam int W = $bits(rec_t);

   // ---------------- clock / reset / DUT ----------------
   logic        clk_i = 1'b0;
   logic        rst_i, if_valid_i, if_ready_o, wb_en_i, ex_ready_i, flush_i;
   logic [31:0] if_instr_i, if_pc_i, r_src_1_dat_i, r_src_2_dat_i, wb_dat_i;
   logic [4:0]  r_src_1_o, r_src_2_o, wb_rd_i;
   logic        id_valid_o, id_is_load_o, id_illegal_o;
   logic [31:0] id_pc_o, id_rs1_dat_o, id_rs2_dat_o, id_imm_o;
   logic [4:0]  id_rd_o;
   logic [6:0]  id_opcode_o, id_funct7_o;
   logic [2:0]  id_funct3_o;

   always #5 clk_i = ~clk_i;

   logic [31:0] regs [32];
   assign r_src_1_dat_i = regs[r_src_1_o];
   assign r_src_2_dat_i = regs[r_src_2_o];

   id_stage dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .if_valid_i(if_valid_i), .if_instr_i(if_instr_i), .if_pc_i(if_pc_i), .if_ready_o(if_ready_o),
      .r_src_1_o(r_src_1_o), .r_src_2_o(r_src_2_o),
      .r_src_1_dat_i(r_src_1_dat_i), .r_src_2_dat_i(r_src_2_dat_i),
      .wb_en_i(wb_en_i), .wb_rd_i(wb_rd_i), .wb_dat_i(wb_dat_i),
      .ex_ready_i(ex_ready_i), .flush_i(flush_i),
      .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_rs1_dat_o(id_rs1_dat_o),
      .id_rs2_dat_o(id_rs2_dat_o), .id_imm_o(id_imm_o), .id_rd_o(id_rd_o),
      .id_opcode_o(id_opcode_o), .id_funct3_o(id_funct3_o), .id_funct7_o(id_funct7_o),
      .id_is_load_o(id_is_load_o), .id_illegal_o(id_illegal_o)
   );

   // ---------------- scoreboard state ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [W-1:0] exp_q[$];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Slot occupancy and the load that most recently left, kept as plain facts.
   logic       m_valid = 1'b0, m_ld = 1'b0, p_valid = 1'b0, m_ready = 1'b0;
   logic [4:0] m_rd = '0, p_rd = '0;

   function automatic int fmt(input logic [6:0] op);
      if (op inside {T_LOAD, T_IMM, T_JALR}) return 1;
      if (op == T_STORE)                     return 2;
      if (op == T_BRANCH)                    return 3;
      if (op inside {T_LUI, T_AUIPC})        return 4;
      if (op == T_JAL)                       return 5;
      return 0;
   endfunction

   function automatic logic [31:0] ref_imm(input logic [31:0] ins);
      logic signed [31:0] s;
      logic [31:0] sx20, sx25, sx31;
      s = ins;
      sx20 = s >>> 20;
      sx25 = s >>> 25;
      sx31 = s >>> 31;
      case (fmt(ins[6:0]))
         1: return sx20;
         2: return (sx25 << 5) | 32'(ins[11:7]);
         3: return (sx31 << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
         4: return ins & 32'hFFFF_F000;
         5: return (sx31 << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic ref_legal(input logic [31:0] ins);
      return (ins[1:0] == 2'b11) &&
             (ins[6:0] inside {T_LOAD, T_IMM, T_JALR, T_STORE, T_BRANCH, T_LUI, T_AUIPC, T_JAL, T_REG, T_SYS});
   endfunction

   function automatic logic [31:0] opnd(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (BYP && wb_en_i && wb_rd_i != 5'd0 && wb_rd_i == r) return wb_dat_i;
      return regs[r];
   endfunction

   function automatic logic hazard(input logic [4:0] r);
      return (r != 5'd0) && ((m_valid && m_ld && m_rd == r) || (p_valid && p_rd == r));
   endfunction

   function automatic logic exp_ready_now();
      logic [6:0] op;
      logic use_a, use_b, stall;
      op = if_instr_i[6:0];
      use_a = !(op inside {T_LUI, T_AUIPC, T_JAL});
      use_b = op inside {T_STORE, T_BRANCH, T_REG};
      stall = (use_a && hazard(if_instr_i[19:15])) || (use_b && hazard(if_instr_i[24:20])) ||
              (!BYP && wb_en_i);
      return !rst_i && !flush_i && (!m_valid || ex_ready_i) && !stall;
   endfunction

   function automatic logic [W-1:0] mk_rec(input logic [31:0] ins, input logic [31:0] pc);
      rec_t r;
      r.pc  = pc;
      r.rs1 = opnd(ins[19:15]);
      r.rs2 = opnd(ins[24:20]);
      r.imm = ref_imm(ins);
      r.rd  = ins[11:7];
      r.opc = ins[6:0];
      r.f3  = ins[14:12];
      r.f7  = ins[31:25];
      r.ld  = (ins[6:0] == T_LOAD);
      r.ill = !ref_legal(ins);
      return r;
   endfunction

   // Model update on the active edge: accepted instructions enter the expected queue.
   always @(posedge clk_i) begin
      logic leaving;
      if (rst_i) begin
         m_valid = 1'b0;
         p_valid = 1'b0;
         exp_q.delete();
      end else begin
         leaving = m_valid && ex_ready_i && m_ld && (m_rd != 5'd0) && !flush_i;
         p_rd    = m_rd;
         p_valid = leaving;
         if (flush_i) begin
            if (m_valid && !ex_ready_i && exp_q.size() > 0) void'(exp_q.pop_front());
            m_valid = 1'b0;
         end else if (if_valid_i && m_ready) begin
            exp_q.push_back(mk_rec(if_instr_i, if_pc_i));
            m_valid = 1'b1;
            m_ld    = (if_instr_i[6:0] == T_LOAD);
            m_rd    = if_instr_i[11:7];
         end else if (ex_ready_i) begin
            m_valid = 1'b0;
         end
      end
   end

   // Monitor on the opposite edge: handshake, index outputs and presented slot.
   always @(negedge clk_i) begin
      rec_t e;
      m_ready = exp_ready_now();
      check("if_ready", if_ready_o, m_ready);
      check("r_src_1", r_src_1_o, if_instr_i[19:15]);
      check("r_src_2", r_src_2_o, if_instr_i[24:20]);
      check("id_valid", id_valid_o, m_valid);
      if (id_valid_o) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            e = rec_t'(exp_q[0]);
            check("pc", id_pc_o, e.pc);
            check("rs1_dat", id_rs1_dat_o, e.rs1);
            check("rs2_dat", id_rs2_dat_o, e.rs2);
            check("imm", id_imm_o, e.imm);
            check("rd", id_rd_o, e.rd);
            check("opcode", id_opcode_o, e.opc);
            check("funct3", id_funct3_o, e.f3);
            check("funct7", id_funct7_o, e.f7);
            check("is_load", id_is_load_o, e.ld);
            check("illegal", id_illegal_o, e.ill);
            if (ex_ready_i) void'(exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   logic [31:0] pc_ctr = 32'h0000_1000;

   task automatic offer(input logic [31:0] ins, output int waits);
      waits = 0;
      pc_ctr += 4;
      if_valid_i = 1'b1;
      if_instr_i = ins;
      if_pc_i    = pc_ctr;
      @(negedge clk_i);
      while (!if_ready_o && waits < 20) begin
         @(posedge clk_i); #1;
         waits++;
         @(negedge clk_i);
      end
      if (!if_ready_o) begin
         n_tests++;
         n_fail++;
         $display("FAIL offer_timeout: instr %08h never accepted", ins);
      end
      @(posedge clk_i); #1;
      if_valid_i = 1'b0;
   endtask

   task automatic idle(input int n);
      if_valid_i = 1'b0;
      repeat (n) begin @(posedge clk_i); #1; end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0] ops [14];
      logic [31:0] r;
      ops = '{T_LOAD, T_LOAD, T_IMM, T_JALR, T_STORE, T_BRANCH, T_LUI, T_AUIPC,
              T_JAL, T_REG, T_REG, T_SYS, 7'b1111111, 7'b0110001};
      r = $urandom;
      r[6:0]   = ops[$urandom_range(0, 13)];
      r[11:7]  = 5'($urandom_range(0, 7));
      r[19:15] = 5'($urandom_range(0, 7));
      r[24:20] = 5'($urandom_range(0, 7));
      return r;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int w;
      logic have, acc;
      logic [31:0] cur;
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      regs[0] = 32'hDEAD_BEEF;
      rst_i = 1'b1; if_valid_i = 1'b0; if_instr_i = '0; if_pc_i = '0;
      wb_en_i = 1'b0; wb_rd_i = '0; wb_dat_i = '0; ex_ready_i = 1'b1; flush_i = 1'b0;

      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check("reset_outputs", {id_valid_o, id_pc_o, id_rs1_dat_o, id_rs2_dat_o, id_imm_o, id_rd_o,
                              id_opcode_o, id_funct3_o, id_funct7_o, id_is_load_o, id_illegal_o}, '0);
      check("reset_if_ready", if_ready_o, 1'b0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      // addi x1,x0,-5
      offer(32'hFFB0_0093, w);
      @(negedge clk_i);
      check("addi_imm", id_imm_o, 32'hFFFF_FFFB);
      check("addi_rd", id_rd_o, 5'd1);
      check("addi_rs1_x0", id_rs1_dat_o, 32'd0);
      @(posedge clk_i); #1;

      // lw x5,0(x2) ; add x6,x5,x5
      offer(32'h0001_2283, w);
      offer(32'h0052_8333, w);
      check("load_use_waits", w, 2);
      idle(2);

      // hold under back-pressure, then flush
      ex_ready_i = 1'b0;
      offer(32'h0070_0213, w);
      if_valid_i = 1'b1; if_instr_i = 32'h0010_0093; if_pc_i = pc_ctr + 4;
      repeat (3) begin
         @(negedge clk_i);
         check("hold_if_ready", if_ready_o, 1'b0);
         @(posedge clk_i); #1;
      end
      flush_i = 1'b1;
      @(posedge clk_i); #1;
      flush_i = 1'b0; if_valid_i = 1'b0; ex_ready_i = 1'b1;
      @(negedge clk_i);
      check("flush_valid", id_valid_o, 1'b0);
      @(posedge clk_i); #1;

      // add x3,x4,x4 during a write to x4
      wb_en_i = 1'b1; wb_rd_i = 5'd4; wb_dat_i = 32'h0000_1234;
      if_valid_i = 1'b1; if_instr_i = 32'h0042_01B3; pc_ctr += 4; if_pc_i = pc_ctr;
      @(negedge clk_i);
      check("wb_cycle_ready", if_ready_o, BYP);
      @(posedge clk_i); #1;
      wb_en_i = 1'b0;
      if (!BYP) offer(32'h0042_01B3, w);
      if_valid_i = 1'b0;
      @(negedge clk_i);
      check("wb_rs1_dat", id_rs1_dat_o, BYP ? 32'h0000_1234 : regs[4]);
      @(posedge clk_i); #1;

      // illegal opcode still flows
      offer(32'h0000_007F, w);
      @(negedge clk_i);
      check("illegal_flag", id_illegal_o, 1'b1);
      @(posedge clk_i); #1;

      // randomized traffic; the fetch side holds an offer until it is taken
      have = 1'b0;
      cur  = '0;
      for (int c = 0; c < 2500; c++) begin
         if (!have && $urandom_range(0, 3) != 0) begin
            have = 1'b1;
            cur  = rand_instr();
            pc_ctr += 4;
         end
         if_valid_i = have; if_instr_i = cur; if_pc_i = pc_ctr;
         ex_ready_i = ($urandom_range(0, 3) != 0);
         flush_i    = ($urandom_range(0, 30) == 0);
         rst_i      = ($urandom_range(0, 600) == 0);
         wb_en_i    = ($urandom_range(0, 4) == 0);
         wb_rd_i    = 5'($urandom_range(0, 7));
         wb_dat_i   = $urandom;
         @(negedge clk_i);
         acc = have && if_ready_o;
         @(posedge clk_i); #1;
         if (acc) have = 1'b0;
      end

      rst_i = 1'b0; flush_i = 1'b0; wb_en_i = 1'b0; ex_ready_i = 1'b1;
      idle(5);
      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
